// File: rtl/uart_rx_byte.sv
// UART 8N1 receiver: two-flop input synchroniser, mid-bit sampling from a baud
// counter, one-cycle valid / framing_err strobes, LSB-first deserialisation.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       framing_err,
    output logic       busy
);
    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t         state, state_nxt;
    logic           rx_m, rx_s;
    logic [CW-1:0]  cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
    logic           half_done, bit_done, sample;

    assign half_done = (cnt == CW'(HALF_BIT - 1));
    assign bit_done  = (cnt == CW'(CLKS_PER_BIT - 1));

    // Synchroniser presets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (!rx_s) state_nxt = START;
            START:     if (half_done) state_nxt = rx_s ? IDLE : DATA;
            DATA:      if (bit_done && bit_idx == 3'd7) state_nxt = STOP;
            STOP:      if (bit_done) state_nxt = rx_s ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rx_s) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != IDLE);
        sample = ((state == START) && half_done) ||
                 (((state == DATA) || (state == STOP)) && bit_done);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            bit_idx     <= 3'd0;
            shreg       <= 8'h00;
            data        <= 8'h00;
            valid       <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            valid       <= 1'b0;
            framing_err <= 1'b0;
            // Counter is held at zero outside the timed states and restarts on every sample.
            if (sample || (state_nxt != state) || (state == IDLE) || (state == WAIT_IDLE))
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            case (state)
                START: if (half_done) bit_idx <= 3'd0;
                DATA: if (bit_done) begin
                    shreg[bit_idx] <= rx_s;
                    bit_idx        <= bit_idx + 3'd1;
                end
                STOP: if (bit_done) begin
                    if (rx_s) begin
                        data  <= shreg;
                        valid <= 1'b1;
                    end else begin
                        framing_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- UART 8N1 receiver that sits directly upstream of the address counter in the UART path.
- Oversamples the asynchronous rx pin on the system clock and deserialises one byte per frame, LSB first.
- Presents the byte on data with a one-cycle valid strobe. valid drives the counter's d (increment) input; data is written to the addressed location.

Parameters:
- CLKS_PER_BIT, 434, system clocks per bit period (50 MHz / 115200 baud); must be >= 4.
- HALF_BIT, CLKS_PER_BIT/2 (floor), clocks from detected start edge to start-bit midpoint; derived, not overridden.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- rx  in  1  serial input, idle high, asynchronous to clk.
- data  out  8  last correctly framed byte.
- valid  out  1  one-cycle pulse when data is updated.
- framing_err  out  1  one-cycle pulse when stop bit is sampled 0.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Reset (rst=0, async):
  - data=8'h00, valid=0, framing_err=0, busy=0.
  - State=IDLE, bit index=0, baud counter=0.
  - Synchroniser flops preset to 1.
- Input synchroniser: rx passes through 2 flops (rx_s). All decisions use rx_s; pin-to-rx_s latency is 2 clocks.
- Baud counter: counts 0..limit-1, where limit is HALF_BIT in START and CLKS_PER_BIT in DATA/STOP. It clears on every sample and on every state entry.
- FSM:
  - IDLE:
    - busy=0.
    - On rx_s=0 at an edge (call it T0), go to START; busy=1 from the next cycle.
  - START:
    - At T0+HALF_BIT, sample rx_s.
    - 0 -> go to DATA with bit index=0.
    - 1 -> false start: return to IDLE, no output pulse.
  - DATA:
    - Sample every CLKS_PER_BIT clocks after the previous sample.
    - Shift each bit into a shift register at position bit index (LSB first).
    - After bit 7 (index 7), go to STOP.
  - STOP: sample CLKS_PER_BIT after the bit-7 sample.
    - rx_s=1: load data from the shift register and pulse valid for exactly 1 cycle (registered, high in the cycle after the sample edge); go to IDLE.
    - rx_s=0: pulse framing_err for 1 cycle; data is unchanged and valid stays 0; go to WAIT_IDLE.
  - WAIT_IDLE:
    - busy=1.
    - Remain until rx_s=1, then go to IDLE. This prevents a break condition from being read as back-to-back frames.
- Frame timing: the valid pulse occurs T0 + HALF_BIT + 9*CLKS_PER_BIT + 1 clocks after T0.
- Back-to-back frames: a start bit that immediately follows the stop bit must be accepted.
  - Because IDLE is re-entered at the stop-bit midpoint, the next falling edge is detected without loss.
- valid and framing_err are never high in the same cycle.
- valid never exceeds one cycle, regardless of line state.
- data holds its value between frames. Only a valid event or reset changes it.
- Reset mid-frame: the frame is abandoned and all outputs return to reset values at once.
  - After rst=1, the receiver waits in IDLE for the next falling edge.
  - A partially received frame never produces valid.

Test Plan (bench uses CLKS_PER_BIT=16, 20 ns clk; rx is driven at 16 clocks per bit):
- Reset: rst=0 with rx toggling -> data=8'h00, valid=0, framing_err=0, busy=0 throughout; rst=1 with rx=1 -> outputs unchanged.
- Single frame 8'h55 -> exactly one valid pulse 1 cycle wide, data=8'h55, busy falls at the stop-bit midpoint, framing_err stays 0.
- Back-to-back frames 8'hA3 then 8'h01 (no idle gap) -> two valid pulses 160 clocks apart; data=8'hA3 then 8'h01.
- Glitch: rx low for 5 clocks (< HALF_BIT=8), then high -> returns to IDLE, no valid, no framing_err; a following 8'h3C frame is received correctly.
- Framing error: 8'h7E with stop bit 0, then rx held low for 40 clocks, then high -> one framing_err pulse, valid=0, data keeps the prior value, busy=1 until rx_s returns high. Next frame 8'h81 -> data=8'h81.
- Reset mid-frame plus counter chaining:
  - Assert rst during bit 4 of 8'hFF -> no valid.
  - Release, then send 8'h10, 8'h20, 8'h30, 8'h40 into address_counterN (N=2) driven by valid -> address steps 1, 2, 3, 0.
